cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
//  Main state sequencer for the PRV332SV0 core. Drives statu_cpu into the
//  instruction decoder and datapath, and steps each instruction through its
//  flow: if0 -> ex0 -> [mem0 -> [ex1 -> mem1]] -> wb. The flow is selected by
//  the decoder's ins_flow report.
//  Routes illegal instructions, bus faults, ecall/ebreak and interrupts into
//  the exc state. Issues BIU request, instruction-latch, PC-write and retire strobes.
// PARAMETERS
//  TMO_CYC   255  bus-wait cycles before timeout trap (SEQ_BUS_TIMEOUT_EN only)
//  TMO_W     8    width of timeout counter; TMO_CYC < 2**TMO_W
// PORTS
//  clk         in   1  core clock, rising edge
//  rst         in   1  asynchronous reset, active-low
//  ins_flow    in   4  decoder flow: 0001 if_ex_mem_wb, 0010 if_ex_wb, 0011 if_ex_mem_ex_mem_wb, else invalid
//  ill_ins     in   1  decoder illegal-instruction flag
//  ecall       in   1  decoder ecall
//  ebreak      in   1  decoder ebreak
//  int_pend    in   1  enabled interrupt pending (level)
//  rdy_biu     in   1  BIU transfer complete, 1-cycle pulse
//  err_biu     in   1  BIU access/page fault, 1-cycle pulse (wins over rdy_biu)
//  statu_cpu   out  4  state: if0 0000, ex0 0001, mem0 0010, ex1 1001, mem1 1010, wb 0011, exc 1111
//  req_biu     out  1  BIU request, high throughout if0/mem0/mem1
//  ins_lat     out  1  1-cycle pulse: latch fetched word into instruction register
//  pc_wr       out  1  1-cycle pulse: commit next PC (wb->if0)
//  trap        out  1  1-cycle pulse: trap entry (in exc)
//  exc_src     out  3  trap source, valid with trap
//  instret     out  1  1-cycle pulse: instruction retired (in wb)
// BEHAVIOUR
//  Reset (rst=0, async): statu_cpu=if0, all pulses 0, exc_src=000, counter 0.
//   First fetch request is issued in the first cycle after rst deasserts.
//  All outputs are registered or decoded from the state register only. No
//   input-to-output combinational path exists.
//  if0:  err_biu -> exc, src=001 (fetch). rdy_biu -> ex0, with ins_lat pulsed
//        on the same edge. Otherwise hold.
//  ex0:  Fixed priority:
//        1. ill_ins or invalid ins_flow -> exc, src=000.
//        2. ecall -> exc, src=011.
//        3. ebreak -> exc, src=100.
//        4. flow 0010 -> wb.
//        5. flow 0001 or 0011 -> mem0.
//        Always exactly 1 cycle.
//  mem0: err_biu -> exc, src=010 (ld/st). rdy_biu -> ex1 if flow=0011,
//        else wb. Otherwise hold.
//  ex1:  1 cycle, then -> mem1 (AMO compute stage).
//  mem1: err_biu -> exc, src=010. rdy_biu -> wb. Otherwise hold.
//  wb:   1 cycle. instret=1.
//        int_pend=1 -> exc, src=101; pc_wr NOT pulsed (trap logic supplies PC).
//        Otherwise -> if0 with pc_wr=1.
//        Interrupts are sampled only in wb, so an instruction is never split.
//  exc:  1 cycle. trap=1. Then -> if0.
//  ins_flow is sampled only in ex0 and mem0. The decoder holds it stable
//   from ins_lat until the next ins_lat.
//  Simultaneous rdy_biu and err_biu: the error wins.
//  A rdy_biu or err_biu pulse outside if0/mem0/mem1 is ignored.
//  Latency, zero wait states: ALU op 3 cycles (if0, ex0, wb);
//   load/store 4 cycles; AMO 6 cycles.
//  Reset asserted mid-bus-cycle: state returns to if0 immediately and
//   req_biu drops asynchronously. The BIU must abort on !req_biu.
//  Undefined state encodings -> exc, src=111, next cycle (self-recovery).
// CONFIGURATION
//  SEQ_BUS_TIMEOUT_EN defined:
//   - A TMO_W-bit counter increments each cycle spent in if0/mem0/mem1
//     without rdy_biu or err_biu.
//   - The counter clears on any state change.
//   - When the count reaches TMO_CYC: -> exc, src=110, req_biu drops.
//     This is TMO_CYC+1 cycles after entering the wait state.
//   - rdy_biu arriving in the same cycle the count reaches TMO_CYC still wins.
//  SEQ_BUS_TIMEOUT_EN undefined: no counter; bus wait states hold indefinitely.
//   src=110 is never produced.
// TESTING
//  1. Reset release, ADDI (flow 0010), rdy_biu 1 cycle after req:
//     states 0000,0000,0001,0011,0000. ins_lat, instret and pc_wr each pulse once.
//  2. LW (flow 0001), rdy_biu after 3 wait cycles in mem0:
//     mem0 held 4 cycles, then wb. instret=1.
//  3. AMOADD (flow 0011): sequence if0,ex0,mem0,ex1,mem1,wb.
//     req_biu high in mem0 and mem1 only.
//  4. ill_ins=1 in ex0: next state 1111 with trap=1, exc_src=000, then if0.
//     No instret, no pc_wr.
//  5. int_pend=1 arriving during mem0 of a SW:
//     SW completes through wb (instret=1), then exc with src=101.
//  6. SEQ_BUS_TIMEOUT_EN, TMO_CYC=4, no rdy_biu in if0:
//     exc after 5 cycles in if0, src=110.
//     Repeat with rdy_biu and err_biu together: exc, src=001.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: main state sequencer for the PRV332SV0 core.
// Steps each instruction through if0 -> ex0 -> [mem0 -> [ex1 -> mem1]] -> wb
// and routes faults, ecall/ebreak, interrupts and bad states into exc.
// Optional feature macro: SEQ_BUS_TIMEOUT_EN (bus wait-state timeout trap).
module cpu_seq_ctrl #(
    parameter int unsigned TMO_CYC = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_ins_flow,
    input  logic       i_ill_ins,
    input  logic       i_ecall,
    input  logic       i_ebreak,
    input  logic       i_int_pend,
    input  logic       i_rdy_biu,
    input  logic       i_err_biu,
    output logic [3:0] o_statu_cpu,
    output logic       o_req_biu,
    output logic       o_ins_lat,
    output logic       o_pc_wr,
    output logic       o_trap,
    output logic [2:0] o_exc_src,
    output logic       o_instret
);

    typedef enum logic [3:0] {
        S_IF0  = 4'b0000,
        S_EX0  = 4'b0001,
        S_MEM0 = 4'b0010,
        S_WB   = 4'b0011,
        S_EX1  = 4'b1001,
        S_MEM1 = 4'b1010,
        S_EXC  = 4'b1111
    } state_t;

    localparam logic [3:0] FLOW_LDST = 4'b0001;
    localparam logic [3:0] FLOW_ALU  = 4'b0010;
    localparam logic [3:0] FLOW_AMO  = 4'b0011;

    localparam logic [2:0] SRC_ILL   = 3'b000;
    localparam logic [2:0] SRC_FETCH = 3'b001;
    localparam logic [2:0] SRC_LDST  = 3'b010;
    localparam logic [2:0] SRC_ECALL = 3'b011;
    localparam logic [2:0] SRC_EBRK  = 3'b100;
    localparam logic [2:0] SRC_INT   = 3'b101;
    localparam logic [2:0] SRC_TMO   = 3'b110;
    localparam logic [2:0] SRC_BADST = 3'b111;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYC);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_exc_src;
    logic [2:0] w_exc_src_next;
    logic       r_ins_lat;
    logic       w_ins_lat_next;
    logic       r_pc_wr;
    logic       w_pc_wr_next;
    // Cleared by reset so no request is visible while reset is held; the
    // first fetch request follows the first clock after reset release.
    logic       r_run;
    logic       w_bus_state;
    logic       w_bus_wait;
    logic       w_flow_ok;
    logic       w_tmo;

    assign w_bus_state = (r_state == S_IF0) || (r_state == S_MEM0) || (r_state == S_MEM1);
    assign w_bus_wait  = r_run && w_bus_state && !i_rdy_biu && !i_err_biu;
    assign w_flow_ok   = (i_ins_flow == FLOW_LDST) || (i_ins_flow == FLOW_ALU) ||
                         (i_ins_flow == FLOW_AMO);

`ifdef SEQ_BUS_TIMEOUT_EN
    logic [TMO_W-1:0] r_cnt;

    assign w_tmo = (r_cnt == TMO_LIMIT);

    // Wait-state counter: counts idle bus cycles, clears on any state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_bus_wait && (w_state_next == r_state)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    // No timeout: bus wait states hold indefinitely (expression is constant 0)
    assign w_tmo = (TMO_LIMIT == '0) & 1'b0;
`endif

    // State and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IF0;
            r_exc_src <= 3'b000;
            r_ins_lat <= 1'b0;
            r_pc_wr   <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_exc_src <= w_exc_src_next;
            r_ins_lat <= w_ins_lat_next;
            r_pc_wr   <= w_pc_wr_next;
            r_run     <= 1'b1;
        end
    end

    // Next-state, trap source and strobe decode
    always_comb begin
        w_state_next   = r_state;
        w_exc_src_next = r_exc_src;
        w_ins_lat_next = 1'b0;
        w_pc_wr_next   = 1'b0;
        case (r_state)
            S_IF0: begin
                if (r_run) begin
                    if (i_err_biu) begin
                        w_state_next   = S_EXC;
                        w_exc_src_next = SRC_FETCH;
                    end else if (i_rdy_biu) begin
                        w_state_next   = S_EX0;
                        w_ins_lat_next = 1'b1;
                    end else if (w_tmo) begin
                        w_state_next   = S_EXC;
                        w_exc_src_next = SRC_TMO;
                    end
                end
            end
            S_EX0: begin
                if (i_ill_ins || !w_flow_ok) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_ILL;
                end else if (i_ecall) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_ECALL;
                end else if (i_ebreak) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_EBRK;
                end else if (i_ins_flow == FLOW_ALU) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = S_MEM0;
                end
            end
            S_MEM0, S_MEM1: begin
                if (i_err_biu) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_LDST;
                end else if (i_rdy_biu) begin
                    // Only the first memory phase of an AMO continues to ex1
                    w_state_next = ((r_state == S_MEM0) && (i_ins_flow == FLOW_AMO)) ? S_EX1 : S_WB;
                end else if (w_tmo) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_TMO;
                end
            end
            S_EX1: begin
                w_state_next = S_MEM1;
            end
            S_WB: begin
                // Interrupts are taken only here, between whole instructions
                if (i_int_pend) begin
                    w_state_next   = S_EXC;
                    w_exc_src_next = SRC_INT;
                end else begin
                    w_state_next = S_IF0;
                    w_pc_wr_next = 1'b1;
                end
            end
            S_EXC: begin
                w_state_next = S_IF0;
            end
            default: begin
                w_state_next   = S_EXC;
                w_exc_src_next = SRC_BADST;
            end
        endcase
    end

    assign o_statu_cpu = r_state;
    assign o_req_biu   = r_run && w_bus_state;
    assign o_ins_lat   = r_ins_lat;
    assign o_pc_wr     = r_pc_wr;
    assign o_trap      = (r_state == S_EXC);
    assign o_exc_src   = r_exc_src;
    assign o_instret   = (r_state == S_WB);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed self-checking bench for cpu_seq_ctrl.
// Timeout checks are built when SEQ_BUS_TIMEOUT_EN is defined (TMO_CYC=4).
module tb_cpu_seq_ctrl;

    localparam logic [3:0] IF0  = 4'b0000;
    localparam logic [3:0] EX0  = 4'b0001;
    localparam logic [3:0] MEM0 = 4'b0010;
    localparam logic [3:0] WB   = 4'b0011;
    localparam logic [3:0] EX1  = 4'b1001;
    localparam logic [3:0] MEM1 = 4'b1010;
    localparam logic [3:0] EXC  = 4'b1111;

    // Strobe patterns {req_biu, ins_lat, pc_wr, trap, instret}
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_REQ   = 5'b10000;
    localparam logic [4:0] P_REQPC = 5'b10100;
    localparam logic [4:0] P_LAT   = 5'b01000;
    localparam logic [4:0] P_TRAP  = 5'b00010;
    localparam logic [4:0] P_RET   = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ins_flow;
    logic       ill_ins, ecall, ebreak, int_pend, rdy_biu, err_biu;
    logic [3:0] statu_cpu;
    logic       req_biu, ins_lat, pc_wr, trap, instret;
    logic [2:0] exc_src;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cpu_seq_ctrl #(.TMO_CYC(4), .TMO_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ins_flow  (ins_flow),
        .i_ill_ins   (ill_ins),
        .i_ecall     (ecall),
        .i_ebreak    (ebreak),
        .i_int_pend  (int_pend),
        .i_rdy_biu   (rdy_biu),
        .i_err_biu   (err_biu),
        .o_statu_cpu (statu_cpu),
        .o_req_biu   (req_biu),
        .o_ins_lat   (ins_lat),
        .o_pc_wr     (pc_wr),
        .o_trap      (trap),
        .o_exc_src   (exc_src),
        .o_instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] st, input logic [4:0] p);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {statu_cpu, req_biu, ins_lat, pc_wr, trap, instret};
        exp = {st, p};
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: state=%b strobes=%b", tag, statu_cpu, obs[4:0]);
        end else begin
            n_fail++;
            $error("FAIL %s: observed state/strobes=%b/%b expected %b/%b",
                   tag, obs[8:5], obs[4:0], exp[8:5], exp[4:0]);
        end
    endtask

    task automatic chk_src(input string tag, input logic [2:0] exp);
        n_total++;
        assert (exc_src === exp) begin
            n_pass++;
            $display("check %s: exc_src=%b", tag, exc_src);
        end else begin
            n_fail++;
            $error("FAIL %s: observed exc_src=%b expected %b", tag, exc_src, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ins_flow = 4'b0010;
        ill_ins = 1'b0; ecall = 1'b0; ebreak = 1'b0;
        int_pend = 1'b0; rdy_biu = 1'b0; err_biu = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", IF0, P_NONE);
        chk_src("reset_src", 3'b000);
        rst_n = 1'b1;

        // 1: ADDI, fetch completes in the first request cycle
        tick(); expect_out("addi_if0", IF0, P_REQ);
        rdy_biu = 1'b1;
        tick(); expect_out("addi_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("addi_wb", WB, P_RET);
        tick(); expect_out("addi_if0_next", IF0, P_REQPC);

        // 2: LW with three wait cycles in mem0
        ins_flow = 4'b0001; rdy_biu = 1'b1;
        tick(); expect_out("lw_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out($sformatf("lw_mem0_%0d", i), MEM0, P_REQ);
        end
        rdy_biu = 1'b1;
        tick(); expect_out("lw_wb", WB, P_RET);
        rdy_biu = 1'b0;
        tick(); expect_out("lw_if0", IF0, P_REQPC);

        // 3: AMOADD, plus a stray err_biu in wb that must be ignored
        ins_flow = 4'b0011; rdy_biu = 1'b1;
        tick(); expect_out("amo_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("amo_mem0", MEM0, P_REQ);
        rdy_biu = 1'b1;
        tick(); expect_out("amo_ex1", EX1, P_NONE);
        rdy_biu = 1'b0;
        tick(); expect_out("amo_mem1", MEM1, P_REQ);
        rdy_biu = 1'b1;
        tick(); expect_out("amo_wb", WB, P_RET);
        rdy_biu = 1'b0; err_biu = 1'b1;
        tick(); expect_out("amo_if0", IF0, P_REQPC);
        err_biu = 1'b0;

        // 4: illegal instruction
        ins_flow = 4'b0010; rdy_biu = 1'b1;
        tick(); expect_out("ill_ex0", EX0, P_LAT);
        rdy_biu = 1'b0; ill_ins = 1'b1;
        tick(); expect_out("ill_exc", EXC, P_TRAP); chk_src("ill_src", 3'b000);
        ill_ins = 1'b0;
        tick(); expect_out("ill_if0", IF0, P_REQ);

        // 5: SW with interrupt raised during mem0
        ins_flow = 4'b0001; rdy_biu = 1'b1;
        tick(); expect_out("sw_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("sw_mem0_a", MEM0, P_REQ);
        int_pend = 1'b1;
        tick(); expect_out("sw_mem0_b", MEM0, P_REQ);
        rdy_biu = 1'b1;
        tick(); expect_out("sw_wb", WB, P_RET);
        rdy_biu = 1'b0;
        tick(); expect_out("sw_int_exc", EXC, P_TRAP); chk_src("int_src", 3'b101);
        int_pend = 1'b0;
        tick(); expect_out("sw_if0", IF0, P_REQ);

        // ecall and ebreak together: ecall has priority
        ins_flow = 4'b0010; rdy_biu = 1'b1;
        tick(); expect_out("ecall_ex0", EX0, P_LAT);
        rdy_biu = 1'b0; ecall = 1'b1; ebreak = 1'b1;
        tick(); expect_out("ecall_exc", EXC, P_TRAP); chk_src("ecall_src", 3'b011);
        ecall = 1'b0; ebreak = 1'b0;
        tick(); expect_out("ecall_if0", IF0, P_REQ);

        // ebreak alone
        rdy_biu = 1'b1;
        tick(); expect_out("ebrk_ex0", EX0, P_LAT);
        rdy_biu = 1'b0; ebreak = 1'b1;
        tick(); expect_out("ebrk_exc", EXC, P_TRAP); chk_src("ebrk_src", 3'b100);
        ebreak = 1'b0;
        tick(); expect_out("ebrk_if0", IF0, P_REQ);

        // invalid flow code
        ins_flow = 4'b0000; rdy_biu = 1'b1;
        tick(); expect_out("badflow_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("badflow_exc", EXC, P_TRAP); chk_src("badflow_src", 3'b000);
        tick(); expect_out("badflow_if0", IF0, P_REQ);

        // load fault with rdy and err together: error wins
        ins_flow = 4'b0001; rdy_biu = 1'b1;
        tick(); expect_out("ldf_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("ldf_mem0", MEM0, P_REQ);
        rdy_biu = 1'b1; err_biu = 1'b1;
        tick(); expect_out("ldf_exc", EXC, P_TRAP); chk_src("ldf_src", 3'b010);
        rdy_biu = 1'b0; err_biu = 1'b0;
        tick(); expect_out("ldf_if0", IF0, P_REQ);

        // fetch fault
        err_biu = 1'b1;
        tick(); expect_out("ff_exc", EXC, P_TRAP); chk_src("ff_src", 3'b001);
        err_biu = 1'b0;
        tick(); expect_out("ff_if0", IF0, P_REQ);

`ifdef SEQ_BUS_TIMEOUT_EN
        // Timeout: five cycles in if0 then exc with src 110
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out($sformatf("tmo_if0_%0d", i), IF0, P_REQ);
        end
        tick(); expect_out("tmo_exc", EXC, P_TRAP); chk_src("tmo_src", 3'b110);
        tick(); expect_out("tmo_if0", IF0, P_REQ);
        // At the limit with rdy and err together: fetch fault wins
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out($sformatf("tmo2_if0_%0d", i), IF0, P_REQ);
        end
        rdy_biu = 1'b1; err_biu = 1'b1;
        tick(); expect_out("tmo2_exc", EXC, P_TRAP); chk_src("tmo2_src", 3'b001);
        rdy_biu = 1'b0; err_biu = 1'b0;
        tick(); expect_out("tmo2_if0", IF0, P_REQ);
`else
        // Without timeout, if0 waits indefinitely
        repeat (300) tick();
        expect_out("hold_if0", IF0, P_REQ);
`endif

        // Reset mid-bus-cycle: state and request drop without a clock edge
        ins_flow = 4'b0001; rdy_biu = 1'b1;
        tick(); expect_out("rstm_ex0", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("rstm_mem0", MEM0, P_REQ);
        rst_n = 1'b0;
        #1;
        expect_out("rstm_async", IF0, P_NONE);
        rst_n = 1'b1;
        tick(); expect_out("rstm_if0", IF0, P_REQ);
        ins_flow = 4'b0010; rdy_biu = 1'b1;
        tick(); expect_out("rstm_ex0b", EX0, P_LAT);
        rdy_biu = 1'b0;
        tick(); expect_out("rstm_wb", WB, P_RET);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
